coherence_bus_ctrl: RTL
=======================

# coherence_bus_ctrl

Shared memory bus controller for the dual-core build. Arbitrates one RAM port among two dcaches and two icaches, and sequences snoops for each dcache miss. Dirty snoop hits are serviced by cache-to-cache transfer; clean or absent lines are read from RAM. Sits between the per-core `caches_if` bundles and the RAM model.

## Interface

Parameters:
- `CPUS`, 2: number of cores. Only 2 is supported.

Ports (clock and reset first):
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `iREN` in [CPUS]: icache read request.
- `iaddr` in [CPUS]×32: icache word address.
- `iwait` out [CPUS]: low for the one cycle the icache read completes.
- `iload` out [CPUS]×32: icache read data.
- `dREN` in [CPUS]: dcache block-word read request.
- `dWEN` in [CPUS]: dcache write request (writeback, flush or snoop supply).
- `daddr` in [CPUS]×32: dcache word address.
- `dstore` in [CPUS]×32: dcache write data.
- `dwait` out [CPUS]: low for the one cycle the dcache access completes.
- `dload` out [CPUS]×32: dcache read data.
- `ccwrite` in [CPUS]: requester intends to write (invalidating miss).
- `cctrans` in [CPUS]: snooper has finished its response. Held high when idle.
- `ccwait` out [CPUS]: snoop in progress on that core.
- `ccinv` out [CPUS]: invalidate snooped line.
- `ccsnoopaddr` out [CPUS]×32: address to snoop.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: RAM status `{FREE, BUSY, ACCESS, ERROR}`; ACCESS means the current access completes this cycle.

## Operation

- States:
  - IDLE
  - ARB
  - WB
  - SNOOP
  - C2C1, C2C2
  - RAMRD1, RAMRD2
  - IFETCH
- Priority in ARB, highest first:
  1. Any `dWEN` (writeback).
  2. Any `dREN` (miss).
  3. Any `iREN`.
  - Within each class, a 2-way round-robin pointer per class selects the core. The pointer flips to the loser after each grant.
- IDLE→ARB whenever any request is high. ARB latches the granted core `g` and goes to WB, SNOOP or IFETCH.
- WB:
  - Drive `ramWEN=1`, `ramaddr=daddr[g]`, `ramstore=dstore[g]`.
  - On ACCESS: `dwait[g]=0` for that cycle, then →IDLE. Each writeback word is a separate grant.
- SNOOP (requester `g`, snooper `s=~g`):
  - `ccwait[s]=1`, `ccsnoopaddr[s]=daddr[g]`, `ccinv[s]=ccwrite[g]`.
  - If `dWEN[s]` is high: →C2C1 (dirty supply).
  - Else if `cctrans[s]` is high: →RAMRD1.
  - Else stay.
- C2C1/C2C2:
  - Hold `ccwait[s]=1`.
  - RAM write of `dstore[s]` at `daddr[s]`; `dload[g]=dstore[s]`.
  - On ACCESS: `dwait[s]=0` and `dwait[g]=0` in the same cycle. C2C1→C2C2, C2C2→IDLE.
- RAMRD1/RAMRD2:
  - `ramREN=1`, `ramaddr=daddr[g]`, `dload[g]=ramload`.
  - On ACCESS: `dwait[g]=0`. RAMRD1→RAMRD2, RAMRD2→IDLE.
- IFETCH:
  - `ramREN=1`, `ramaddr=iaddr[g]`, `iload[g]=ramload`.
  - On ACCESS: `iwait[g]=0`, then →IDLE.
- Requesters hold their request and address until their wait drops. The controller never aborts a granted transaction, even if the request is deasserted.
- `ramstate` ERROR and BUSY are both treated as not-done; the same access is retried.

## Timing

- Reset values:
  - State IDLE; both round-robin pointers 0.
  - All `iwait`/`dwait` = 1.
  - `ccwait`, `ccinv`, `ramREN`, `ramWEN` = 0.
  - Data and address outputs = 0.
- Reset asserted mid-transaction returns to IDLE immediately; no RAM enable survives.
- Grant latency: request at cycle 0 → ARB at 1 → RAM enable at 2. With zero-wait RAM, a RAM miss completes in 5 cycles and a single word in 3.
- `dwait`/`iwait` are 1 in every cycle other than the completion cycle.
- Both cores missing the same address: the first (by pointer) is served and the second snoops it afterwards.
- `dWEN` on core `s` while it is being snooped is a snoop supply, not a new writeback.

## Configuration

- `C2C_FORWARD_EN` defined: C2C states as above; the requester receives the data in the same cycle the supplier writes it.
- `C2C_FORWARD_EN` undefined:
  - Dirty supply performs RAM write only; `dwait[g]` stays 1.
  - After C2C2, go to RAMRD1 for requester `g`.
  - Cost: 2 extra RAM accesses.

## Structure

- `cpu_types_pkg` gains:
  - `busstate_t` enum for the states.
  - `ramstate_t` if not already present.
  - `CPUS` localparam.
- One sub-module: `rr_arbiter2`, a 2-input round-robin pointer with grant output and advance strobe. Instantiate it three times, one per priority class.

## Test plan

- Core0 `dREN`, `daddr=0x100`, core1 `cctrans=1`, RAM ACCESS every cycle → `ccwait[1]` high with `ccsnoopaddr[1]=0x100`, then `ramREN`; `dwait[0]` low twice with `dload=ramload`.
- Core0 `dREN` at `0x200`, core1 answers with `dWEN`, `dstore=0xDEAD`:
  - With `C2C_FORWARD_EN`: `dload[0]=0xDEAD`, `ramWEN` at `0x200`, `dwait[0]` and `dwait[1]` low together.
  - Without it: RAM write first, then RAM read.
- Both cores `iREN` continuously → grants alternate 0,1,0,1.
- Core0 `dREN` and core1 `dWEN` in the same cycle → writeback granted first.
- Core1 `dREN` with `ccwrite=1` → `ccinv[0]=1` during SNOOP.
- `ramstate=BUSY` for 3 cycles during RAMRD1 → `ramREN` held, `dwait` stays high; `RST` asserted then → IDLE, all enables 0 next cycle.

Source files
------------

// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types and constants for the dual-core coherence bus controller.
package coherence_bus_ctrl_pkg;

  localparam int CPUS   = 2;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ARB    = 4'd1,
    WB     = 4'd2,
    SNOOP  = 4'd3,
    C2C1   = 4'd4,
    C2C2   = 4'd5,
    RAMRD1 = 4'd6,
    RAMRD2 = 4'd7,
    IFETCH = 4'd8
  } busstate_t;

  // BUSY and ERROR both mean the same access must be retried.
  function automatic logic ram_done(input ramstate_t rs);
    return rs == ACCESS;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Cache-side and RAM-side signals of the coherence bus; master is the controller.
interface coherence_bus_ctrl_if;
  import coherence_bus_ctrl_pkg::*;

  logic [CPUS-1:0]             iREN;
  logic [CPUS-1:0][WORD_W-1:0] iaddr;
  logic [CPUS-1:0]             iwait;
  logic [CPUS-1:0][WORD_W-1:0] iload;

  logic [CPUS-1:0]             dREN;
  logic [CPUS-1:0]             dWEN;
  logic [CPUS-1:0][WORD_W-1:0] daddr;
  logic [CPUS-1:0][WORD_W-1:0] dstore;
  logic [CPUS-1:0]             dwait;
  logic [CPUS-1:0][WORD_W-1:0] dload;

  logic [CPUS-1:0]             ccwrite;
  logic [CPUS-1:0]             cctrans;
  logic [CPUS-1:0]             ccwait;
  logic [CPUS-1:0]             ccinv;
  logic [CPUS-1:0][WORD_W-1:0] ccsnoopaddr;

  logic                        ramREN;
  logic                        ramWEN;
  word_t                       ramaddr;
  word_t                       ramstore;
  word_t                       ramload;
  ramstate_t                   ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans,
           ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans,
           ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/coherence_bus_ctrl_arb.sv
// Two-way round-robin pointer: a lone requester always wins, a tie goes to the
// pointer, and every accepted grant hands priority to the other core.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);

  logic ptr;

  always_comb begin
    grant = ptr;
    if (req == 2'b01) begin
      grant = 1'b0;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~grant;
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Shared RAM bus controller with snoop sequencing for the dual-core build.
// Optional macro C2C_FORWARD_EN: dirty snoop data goes straight to the requester.
module coherence_bus_ctrl #(
  parameter int CPUS = 2
) (
  input logic                  CLK,
  input logic                  RST,
  coherence_bus_ctrl_if.master bus
);
  import coherence_bus_ctrl_pkg::*;

  busstate_t       state, state_n;
  logic            gnt, gnt_n;
  logic            snp;
  logic            done;
  logic            wb_gnt, rd_gnt, if_gnt;
  logic            wb_adv, rd_adv, if_adv;
  logic [CPUS-1:0] snoop_mask_n;

  assign snp          = ~gnt;
  assign done         = ram_done(bus.ramstate);
  assign snoop_mask_n = gnt_n ? 2'b01 : 2'b10;

  rr_arbiter2 u_wb_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (bus.dWEN),
    .advance (wb_adv),
    .grant   (wb_gnt)
  );

  rr_arbiter2 u_rd_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (bus.dREN),
    .advance (rd_adv),
    .grant   (rd_gnt)
  );

  rr_arbiter2 u_if_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (bus.iREN),
    .advance (if_adv),
    .grant   (if_gnt)
  );

  // Writebacks beat misses beat instruction fetches; only the winning class advances.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    wb_adv  = 1'b0;
    rd_adv  = 1'b0;
    if_adv  = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.dWEN || |bus.dREN || |bus.iREN) begin
          state_n = ARB;
        end
      end
      ARB: begin
        if (|bus.dWEN) begin
          state_n = WB;
          gnt_n   = wb_gnt;
          wb_adv  = 1'b1;
        end else if (|bus.dREN) begin
          state_n = SNOOP;
          gnt_n   = rd_gnt;
          rd_adv  = 1'b1;
        end else if (|bus.iREN) begin
          state_n = IFETCH;
          gnt_n   = if_gnt;
          if_adv  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      WB: begin
        if (done) begin
          state_n = IDLE;
        end
      end
      SNOOP: begin
        if (bus.dWEN[snp]) begin
          state_n = C2C1;
        end else if (bus.cctrans[snp]) begin
          state_n = RAMRD1;
        end
      end
      C2C1: begin
        if (done) begin
          state_n = C2C2;
        end
      end
      C2C2: begin
        if (done) begin
`ifdef C2C_FORWARD_EN
          state_n = IDLE;
`else
          state_n = RAMRD1;
`endif
        end
      end
      RAMRD1: begin
        if (done) begin
          state_n = RAMRD2;
        end
      end
      RAMRD2: begin
        if (done) begin
          state_n = IDLE;
        end
      end
      IFETCH: begin
        if (done) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Enables are registered from the next state so an async reset kills them at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      bus.ramREN <= 1'b0;
      bus.ramWEN <= 1'b0;
      bus.ccwait <= '0;
      bus.ccinv  <= '0;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      bus.ramREN <= (state_n == RAMRD1) || (state_n == RAMRD2) || (state_n == IFETCH);
      bus.ramWEN <= (state_n == WB) || (state_n == C2C1) || (state_n == C2C2);
      bus.ccwait <= ((state_n == SNOOP) || (state_n == C2C1) || (state_n == C2C2))
                    ? snoop_mask_n : '0;
      bus.ccinv  <= ((state_n == SNOOP) && bus.ccwrite[gnt_n]) ? snoop_mask_n : '0;
    end
  end

  // Addresses track the live request so multi-word transfers follow the cache's word address.
  always_comb begin
    bus.iwait       = '1;
    bus.dwait       = '1;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ccsnoopaddr = '0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    case (state)
      WB: begin
        bus.ramaddr    = bus.daddr[gnt];
        bus.ramstore   = bus.dstore[gnt];
        bus.dwait[gnt] = ~done;
      end
      SNOOP: begin
        bus.ccsnoopaddr[snp] = bus.daddr[gnt];
      end
      C2C1, C2C2: begin
        bus.ramaddr    = bus.daddr[snp];
        bus.ramstore   = bus.dstore[snp];
        bus.dload[gnt] = bus.dstore[snp];
        bus.dwait[snp] = ~done;
`ifdef C2C_FORWARD_EN
        bus.dwait[gnt] = ~done;
`endif
      end
      RAMRD1, RAMRD2: begin
        bus.ramaddr    = bus.daddr[gnt];
        bus.dload[gnt] = bus.ramload;
        bus.dwait[gnt] = ~done;
      end
      IFETCH: begin
        bus.ramaddr    = bus.iaddr[gnt];
        bus.iload[gnt] = bus.ramload;
        bus.iwait[gnt] = ~done;
      end
      default: ;
    endcase
  end

endmodule
